// File: rtl/sound_event_sequencer_pkg.sv
// Shared types and note table for the sound event sequencer.
package sound_pkg;

   typedef enum logic [1:0] {EV_NONE, EV_GOOD, EV_BAD, EV_DIR} EVENT_TYPES;
   typedef enum logic [1:0] {IDLE, TONE, GAP} SEQ_STATES;

   localparam int FREQ_W = 9;
   localparam logic [FREQ_W-1:0] FREQ_GOOD = 9'd440;
   localparam logic [FREQ_W-1:0] FREQ_BAD  = 9'd311;
   localparam logic [FREQ_W-1:0] FREQ_DIR  = 9'd262;

   function automatic logic [FREQ_W-1:0] event_to_freq(input EVENT_TYPES ev);
      logic [FREQ_W-1:0] f;
      case (ev)
         EV_GOOD: f = FREQ_GOOD;
         EV_BAD:  f = FREQ_BAD;
         EV_DIR:  f = FREQ_DIR;
         default: f = '0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/sound_event_sequencer_event_fifo.sv
// Small circular FIFO of event codes; a push is accepted when full if a pop happens in the same cycle.
module event_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   input  logic [W-1:0]                 data_i,
   output logic [W-1:0]                 data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o,
   output logic                         empty_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !flush_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !flush_i && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/sound_event_sequencer.sv
// Queues game events and plays each as a fixed-length tone followed by a fixed silent gap.
module sound_event_sequencer
   import sound_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int TONE_TICKS = 25,
   parameter int GAP_TICKS  = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         good_evt,
   input  logic                         bad_evt,
   input  logic                         dir_evt,
   input  logic                         mute,
   output logic [FREQ_W-1:0]            freq,
   output logic                         play,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   queue_count,
   output logic                         drop
);

   localparam int MAXT = (TONE_TICKS > GAP_TICKS) ? TONE_TICKS : GAP_TICKS;
   localparam int TW   = $clog2(MAXT + 1);
   localparam int CW   = $clog2(DEPTH + 1);
   localparam logic [TW-1:0] TONE_LOAD = TW'(TONE_TICKS - 1);
   localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_TICKS - 1);

   SEQ_STATES         state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [FREQ_W-1:0] freq_q, freq_d;
   logic              play_q, play_d;
   logic              drop_q, drop_d;

   EVENT_TYPES        ev_sel;
   logic              evt_multi;
   logic              push, pop;
   logic [1:0]        fifo_head;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full, fifo_empty;

   event_fifo #(
      .DEPTH (DEPTH),
      .W     (2)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (mute),
      .data_i  (ev_sel),
      .data_o  (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // One event per cycle; anything beyond the highest-priority one is lost.
   always_comb begin
      ev_sel = EV_NONE;
      if (bad_evt)       ev_sel = EV_BAD;
      else if (good_evt) ev_sel = EV_GOOD;
      else if (dir_evt)  ev_sel = EV_DIR;
      evt_multi = (bad_evt & good_evt) | (bad_evt & dir_evt) | (good_evt & dir_evt);
      push      = !mute && (ev_sel != EV_NONE) && (!fifo_full || pop);
      drop_d    = !mute && (evt_multi || ((ev_sel != EV_NONE) && fifo_full && !pop));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (mute) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (!fifo_empty) state_d = TONE;
            TONE:    if (timer_q == '0) state_d = GAP;
            GAP:     if (timer_q == '0) state_d = fifo_empty ? IDLE : TONE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      pop     = 1'b0;
      freq_d  = freq_q;
      play_d  = play_q;
      timer_d = timer_q;
      if (mute) begin
         freq_d  = '0;
         play_d  = 1'b0;
         timer_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  freq_d  = event_to_freq(EVENT_TYPES'(fifo_head));
                  play_d  = 1'b1;
                  timer_d = TONE_LOAD;
               end
            end
            TONE: begin
               if (timer_q != '0) begin
                  timer_d = timer_q - 1'b1;
               end else begin
                  freq_d  = '0;
                  play_d  = 1'b0;
                  timer_d = GAP_LOAD;
               end
            end
            GAP: begin
               if (timer_q != '0) begin
                  timer_d = timer_q - 1'b1;
               end else if (!fifo_empty) begin
                  pop     = 1'b1;
                  freq_d  = event_to_freq(EVENT_TYPES'(fifo_head));
                  play_d  = 1'b1;
                  timer_d = TONE_LOAD;
               end
            end
            default: begin
               freq_d  = '0;
               play_d  = 1'b0;
               timer_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
         freq_q  <= '0;
         play_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         timer_q <= timer_d;
         freq_q  <= freq_d;
         play_q  <= play_d;
         drop_q  <= drop_d;
      end
   end

   assign freq        = freq_q;
   assign play        = play_q;
   assign drop        = drop_q;
   assign queue_count = fifo_count;
   assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Randomised and directed bench for sound_event_sequencer against a queue-based timeline model.
module tb_sound_event_sequencer;

   localparam int DEPTH = 4;
   localparam int TONE  = 25;
   localparam int GAP   = 5;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          good_evt, bad_evt, dir_evt, mute;
   logic [8:0]    freq;
   logic          play, busy, drop;
   logic [CW-1:0] queue_count;

   int checks = 0;
   int errors = 0;

   // Model: queue of event codes (1 good, 2 bad, 3 dir), remaining tone / gap cycles.
   int   mq[$];
   int   m_cur;
   int   m_tone;
   int   m_gap;
   logic m_drop;

   sound_event_sequencer #(.DEPTH(DEPTH), .TONE_TICKS(TONE), .GAP_TICKS(GAP)) dut (
      .clk         (clk),
      .rst         (rst),
      .good_evt    (good_evt),
      .bad_evt     (bad_evt),
      .dir_evt     (dir_evt),
      .mute        (mute),
      .freq        (freq),
      .play        (play),
      .busy        (busy),
      .queue_count (queue_count),
      .drop        (drop)
   );

   always #5 clk = ~clk;

   function automatic int note(input int e);
      case (e)
         1: return 440;
         2: return 311;
         3: return 262;
         default: return 0;
      endcase
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_cur  = 0;
      m_tone = 0;
      m_gap  = 0;
      m_drop = 1'b0;
   endfunction

   function automatic void model_edge();
      int  pre;
      int  n;
      int  sel;
      bit  start;
      pre   = mq.size();
      start = 0;
      if (mute) begin
         model_reset();
         return;
      end
      if (m_tone > 1) m_tone--;
      else if (m_tone == 1) begin m_tone = 0; m_gap = GAP; end
      else if (m_gap > 1) m_gap--;
      else begin m_gap = 0; if (pre > 0) start = 1; end
      if (start) begin m_cur = mq.pop_front(); m_tone = TONE; end
      n   = int'(bad_evt) + int'(good_evt) + int'(dir_evt);
      sel = bad_evt ? 2 : good_evt ? 1 : dir_evt ? 3 : 0;
      m_drop = (n > 1);
      if (sel != 0) begin
         if (pre < DEPTH || start) mq.push_back(sel);
         else m_drop = 1'b1;
      end
   endfunction

   function automatic logic [14:0] exp_vec();
      logic [8:0] f;
      f = (m_tone > 0) ? 9'(note(m_cur)) : 9'd0;
      return {f, m_tone > 0, (m_tone > 0 || m_gap > 0 || mq.size() > 0), CW'(mq.size()), m_drop};
   endfunction

   function automatic logic [14:0] obs_vec();
      return {freq, play, busy, queue_count, drop};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge();
      #1;
   endtask

   task automatic set_ev(input logic g, input logic b, input logic d);
      good_evt = g;
      bad_evt  = b;
      dir_evt  = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mute = 1'b0;
      set_ev(0, 0, 0);
      model_reset();
      tick();
      tick();
      checks++;
      if (obs_vec() !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want %h", obs_vec(), 15'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle c%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_single();
      int high;
      high = 0;
      set_ev(1, 0, 0);
      tick();
      set_ev(0, 0, 0);
      checks++;
      if (play !== 1'b0 || queue_count !== CW'(1)) begin
         errors++;
         $display("FAIL single_latency0 got play=%0b qc=%0d want play=0 qc=1", play, queue_count);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         if (play === 1'b1 && freq === 9'd440) high++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL single c%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (high != TONE || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_len got high=%0d busy=%0b want high=%0d busy=0", high, busy, TONE);
      end
   endtask

   task automatic test_order();
      int seq[$];
      int gaps[$];
      int silent;
      logic prev_play;
      prev_play = 1'b0;
      silent = 0;
      set_ev(0, 0, 1); tick();
      set_ev(1, 0, 0); tick();
      set_ev(0, 1, 0); tick();
      set_ev(0, 0, 0);
      for (int i = 0; i < 100; i++) begin
         tick();
         if (play === 1'b1 && prev_play === 1'b0) begin
            seq.push_back(int'(freq));
            if (seq.size() > 1) gaps.push_back(silent);
         end
         if (play === 1'b0) silent++; else silent = 0;
         prev_play = play;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL order c%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (seq.size() != 3 || seq[0] != 262 || seq[1] != 440 || seq[2] != 311) begin
         errors++;
         $display("FAIL order_seq got %p want 262 440 311", seq);
      end
      checks++;
      if (gaps.size() != 2 || gaps[0] != GAP || gaps[1] != GAP) begin
         errors++;
         $display("FAIL order_gaps got %p want %0d %0d", gaps, GAP, GAP);
      end
   endtask

   task automatic test_simul();
      int tones;
      logic prev_play;
      tones = 0;
      prev_play = 1'b0;
      set_ev(1, 1, 1);
      tick();
      set_ev(0, 0, 0);
      checks++;
      if (drop !== 1'b1 || queue_count !== CW'(1)) begin
         errors++;
         $display("FAIL simul_drop got drop=%0b qc=%0d want drop=1 qc=1", drop, queue_count);
      end
      for (int i = 0; i < 35; i++) begin
         tick();
         if (play === 1'b1 && prev_play === 1'b0 && freq === 9'd311) tones++;
         prev_play = play;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL simul c%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (tones != 1) begin
         errors++;
         $display("FAIL simul_tones got %0d want 1", tones);
      end
   endtask

   task automatic test_overflow();
      int drops;
      int r;
      drops = 0;
      for (int i = 0; i < 6; i++) begin
         r = int'($urandom_range(1, 3));
         set_ev(r == 1, r == 2, r == 3);
         tick();
         if (drop === 1'b1) drops++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL overflow_fill c%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      set_ev(0, 0, 0);
      checks++;
      if (drops != 1 || queue_count !== CW'(DEPTH)) begin
         errors++;
         $display("FAIL overflow_drop got drops=%0d qc=%0d want drops=1 qc=%0d", drops, queue_count, DEPTH);
      end
      for (int i = 0; i < 5 * (TONE + GAP) + 5; i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL overflow_play c%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_mute();
      int late;
      late = 0;
      set_ev(1, 0, 0); tick();
      set_ev(0, 0, 1); tick();
      set_ev(0, 1, 0); tick();
      set_ev(0, 0, 0);
      for (int i = 0; i < 9; i++) tick();
      mute = 1'b1;
      tick();
      checks++;
      if (play !== 1'b0 || freq !== 9'd0 || queue_count !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mute_flush got play=%0b freq=%0d qc=%0d busy=%0b want 0 0 0 0", play, freq, queue_count, busy);
      end
      for (int i = 0; i < 6; i++) begin
         set_ev(i[0], i[1], 1'b1);
         tick();
         checks++;
         if (obs_vec() !== exp_vec() || drop !== 1'b0) begin
            errors++;
            $display("FAIL mute_hold c%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      set_ev(0, 0, 0);
      mute = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (play === 1'b1) late++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL mute_release c%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (late != 0) begin
         errors++;
         $display("FAIL mute_no_tone got %0d play cycles want 0", late);
      end
   endtask

   task automatic test_async_reset();
      set_ev(0, 1, 0); tick();
      set_ev(1, 0, 0); tick();
      set_ev(0, 0, 0);
      for (int i = 0; i < 6; i++) tick();
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (obs_vec() !== 15'd0) begin
         errors++;
         $display("FAIL async_reset got %h want %h", obs_vec(), 15'd0);
      end
      model_reset();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL async_after c%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      set_ev(0, 0, 1);
      tick();
      set_ev(0, 0, 0);
      checks++;
      if (play !== 1'b0) begin
         errors++;
         $display("FAIL async_lat1 got play=%0b want 0", play);
      end
      tick();
      checks++;
      if (play !== 1'b1 || freq !== 9'd262) begin
         errors++;
         $display("FAIL async_lat2 got play=%0b freq=%0d want 1 262", play, freq);
      end
      for (int i = 0; i < 35; i++) tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 900; i++) begin
         set_ev($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0);
         if ($urandom_range(0, 59) == 0) mute = ~mute;
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random c%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      set_ev(0, 0, 0);
      mute = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_order();
      test_simul();
      test_overflow();
      test_mute();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
